// File: rtl/multicycle_ctrl_pkg.sv
// Shared state, opcode and datapath-select encodings for the multi-cycle RV32I control path;
// the select encodings are also decoded by the sign-extend unit and the ALU.
package ctrl_pkg;

  typedef enum logic [2:0] {
    s_fetch  = 3'd0,
    s_decode = 3'd1,
    s_exec   = 3'd2,
    s_mem    = 3'd3,
    s_wb     = 3'd4,
    s_trap   = 3'd7
  } state_t;

  localparam logic [6:0] op_r   = 7'b0110011;
  localparam logic [6:0] op_i   = 7'b0010011;
  localparam logic [6:0] op_ld  = 7'b0000011;
  localparam logic [6:0] op_st  = 7'b0100011;
  localparam logic [6:0] op_br  = 7'b1100011;
  localparam logic [6:0] op_jal = 7'b1101111;

  localparam logic [2:0] imm_i = 3'd0;
  localparam logic [2:0] imm_s = 3'd1;
  localparam logic [2:0] imm_b = 3'd2;
  localparam logic [2:0] imm_j = 3'd3;

  localparam logic [1:0] alu_add   = 2'd0;
  localparam logic [1:0] alu_sub   = 2'd1;
  localparam logic [1:0] alu_funct = 2'd2;

  localparam logic [1:0] res_alu = 2'd0;
  localparam logic [1:0] res_mem = 2'd1;
  localparam logic [1:0] res_pc4 = 2'd2;

  function automatic logic op_legal(input logic [6:0] op);
    return op inside {op_r, op_i, op_ld, op_st, op_br, op_jal};
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts request cycles that have not yet seen mem_ready; expired is high while the count is
// TIMEOUT-1, i.e. in the last cycle a stalled request is still allowed to complete.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] last = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == last);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer; enables are combinational from state/instr and a memory stall holds
// the state (up to TIMEOUT cycles, then TRAP). Define MULTICYCLE_INSTRET_EN for the instret counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] instr,
  input  logic        eq,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        reg_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic [2:0]  imm_src,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic [1:0]  result_src,
  output logic        retire,
  output logic        trap,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  state_t     st, st_nxt;
  logic       trap_q;
  logic       expired;
  logic [6:0] opc;
  logic       taken;
  logic       unused_instr;

  assign opc          = instr[6:0];
  assign taken        = eq ^ instr[12];
  assign unused_instr = ^{instr[31:13], instr[11:7]};

  // Outputs are held at zero while reset is asserted so a pending request drops immediately.
  always_comb begin
    st_nxt     = st;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    imm_src    = imm_i;
    alu_src    = 1'b0;
    alu_op     = alu_add;
    result_src = res_alu;
    retire     = 1'b0;
    if (rst) begin
      case (st)
        s_fetch: begin
          if (run) begin
            mem_req = 1'b1;
            if (mem_ready) begin
              ir_we  = 1'b1;
              st_nxt = s_decode;
            end else if (expired) begin
              st_nxt = s_trap;
            end
          end
        end
        s_decode: st_nxt = op_legal(opc) ? s_exec : s_trap;
        s_exec: begin
          case (opc)
            op_r: begin
              alu_op = alu_funct;
              st_nxt = s_wb;
            end
            op_i: begin
              alu_src = 1'b1;
              alu_op  = alu_funct;
              st_nxt  = s_wb;
            end
            op_ld, op_st: begin
              alu_src = 1'b1;
              imm_src = (opc == op_st) ? imm_s : imm_i;
              st_nxt  = s_mem;
            end
            op_br: begin
              alu_op  = alu_sub;
              imm_src = imm_b;
              pc_src  = taken;
              pc_we   = 1'b1;
              retire  = 1'b1;
              st_nxt  = s_fetch;
            end
            op_jal:  st_nxt = s_wb;
            default: st_nxt = s_trap;
          endcase
        end
        s_mem: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opc == op_st);
          if (mem_ready) begin
            if (opc == op_st) begin
              pc_we  = 1'b1;
              retire = 1'b1;
              st_nxt = s_fetch;
            end else begin
              st_nxt = s_wb;
            end
          end else if (expired) begin
            st_nxt = s_trap;
          end
        end
        s_wb: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          retire = 1'b1;
          st_nxt = s_fetch;
          if (opc == op_ld) begin
            result_src = res_mem;
          end else if (opc == op_jal) begin
            result_src = res_pc4;
            pc_src     = 1'b1;
            imm_src    = imm_j;
          end
        end
        default: st_nxt = s_trap;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= s_fetch;
      trap_q <= 1'b0;
    end else begin
      st <= st_nxt;
      if (st_nxt == s_trap) begin
        trap_q <= 1'b1;
      end
    end
  end

  // Any non-request cycle, or a completed request, restarts the wait count.
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk     (clk),
    .rst     (rst),
    .clr     (!mem_req || mem_ready),
    .en      (mem_req && !mem_ready),
    .expired (expired)
  );

  assign state = st;
  assign trap  = trap_q;

`ifdef MULTICYCLE_INSTRET_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a reactive memory responder, a per-instruction timing/outcome
// model feeding an expectation queue, and a monitor that checks every retire and trap entry.
module tb_multicycle_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [31:0] instr = '0;
  logic        eq = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_we, reg_we, pc_we, pc_src, alu_src, retire, trap;
  logic [2:0]  imm_src, state;
  logic [1:0]  alu_op, result_src;
  logic [31:0] instret;

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .eq(eq), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we), .reg_we(reg_we),
    .pc_we(pc_we), .pc_src(pc_src), .imm_src(imm_src), .alu_src(alu_src), .alu_op(alu_op),
    .result_src(result_src), .retire(retire), .trap(trap), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         is_trap;
    int         cyc;
    logic [2:0] state;
    logic       reg_we;
    logic       pc_src;
    logic       mem_we;
    bit         chk_res;
    logic [1:0] result_src;
    bit         chk_imm;
    logic [2:0] imm_src;
  } exp_t;

  exp_t expq[$];
  exp_t mon_x;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_n = 0;
  int   retired = 0;
  int   fdel = 0;
  int   mdel = 0;
  int   rdel = 0;
  int   rcnt = 0;
  bit   resp_mode = 1'b0;
  bit   trap_seen = 1'b0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63 || op == 7'h6F;
  endfunction

  // Outcome from the instruction class and the ready delays (non-ready request cycles before ready).
  function automatic exp_t model(input logic [31:0] ins, input logic e, input int df, input int dm,
                                 input int start);
    exp_t x;
    logic [6:0] op;
    bit is_mem, has_wb;
    op     = ins[6:0];
    is_mem = (op == 7'h03) || (op == 7'h23);
    has_wb = (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h6F);
    x.name = $sformatf("op%02h", op);
    x.is_trap = 1'b0;
    x.reg_we = has_wb;
    x.pc_src = 1'b0;
    x.mem_we = (op == 7'h23);
    x.chk_res = has_wb;
    x.result_src = 2'd0;
    x.chk_imm = 1'b0;
    x.imm_src = 3'd0;
    x.state = has_wb ? 3'd4 : ((op == 7'h63) ? 3'd2 : 3'd3);
    if (df >= TO) begin
      x.is_trap = 1'b1;
      x.cyc = start + TO;
    end else if (!is_legal(op)) begin
      x.is_trap = 1'b1;
      x.cyc = start + df + 2;
    end else if (is_mem && dm >= TO) begin
      x.is_trap = 1'b1;
      x.cyc = start + df + 3 + TO;
    end else begin
      x.cyc = start + (df + 1) + 1 + 1 + (is_mem ? dm + 1 : 0) + (has_wb ? 1 : 0) - 1;
      if (op == 7'h63) begin
        x.pc_src = e ^ ins[12];
        x.chk_imm = 1'b1;
        x.imm_src = 3'd2;
      end
      if (op == 7'h6F) begin
        x.pc_src = 1'b1;
        x.chk_imm = 1'b1;
        x.imm_src = 3'd3;
        x.result_src = 2'd2;
      end
      if (op == 7'h03) x.result_src = 2'd1;
    end
    return x;
  endfunction

  // Memory responder: answers after the programmed delay; random ready noise while idle.
  always @(posedge clk) begin
    #2;
    if (resp_mode || !mem_req) begin
      mem_ready = 1'($urandom_range(0, 1));
      rcnt = 0;
    end else begin
      rdel = addr_sel ? mdel : fdel;
      if (rcnt == rdel) begin
        mem_ready = 1'b1;
        rcnt = 0;
      end else begin
        mem_ready = 1'b0;
        rcnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("pc_we_with_retire", 32'(pc_we), 32'(retire));
      chk("reg_we_outside_retire", 32'(reg_we & ~retire), 32'd0);
      chk("ir_we_on_fetch_ready", 32'(ir_we), 32'(state == 3'd0 && mem_req && mem_ready));
      if (mem_req) chk("addr_sel", 32'(addr_sel), 32'(state == 3'd3));
      if (retire || (trap && !trap_seen)) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: retire=%0b trap=%0b with nothing expected", retire, trap);
        end else begin
          mon_x = expq.pop_front();
          chk({mon_x.name, "_kind"}, 32'({trap, retire}), mon_x.is_trap ? 32'd2 : 32'd1);
          chk({mon_x.name, "_cycle"}, 32'(cyc_n), 32'(mon_x.cyc));
          if (mon_x.is_trap) begin
            chk({mon_x.name, "_trap_state"}, 32'(state), 32'd7);
          end else begin
            chk({mon_x.name, "_state"}, 32'(state), 32'(mon_x.state));
            chk({mon_x.name, "_reg_we"}, 32'(reg_we), 32'(mon_x.reg_we));
            chk({mon_x.name, "_pc_src"}, 32'(pc_src), 32'(mon_x.pc_src));
            chk({mon_x.name, "_mem_we"}, 32'(mem_we), 32'(mon_x.mem_we));
            if (mon_x.chk_res) chk({mon_x.name, "_result_src"}, 32'(result_src), 32'(mon_x.result_src));
            if (mon_x.chk_imm) chk({mon_x.name, "_imm_src"}, 32'(imm_src), 32'(mon_x.imm_src));
`ifdef MULTICYCLE_INSTRET_EN
            chk("instret", instret, 32'(retired));
`else
            chk("instret", instret, 32'd0);
`endif
            retired++;
          end
        end
      end
      trap_seen = trap;
    end else begin
      trap_seen = 1'b0;
    end
  end

  // Entered at posedge+1; asserts reset mid-cycle and releases it away from any rising edge.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    retired = 0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_outputs", 32'({mem_req, mem_we, addr_sel, ir_we, reg_we, pc_we, pc_src, imm_src,
                            alu_src, alu_op, result_src, retire}), 32'd0);
    chk("rst_instret", instret, 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    run = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic trap_recover();
    resp_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("trap_hold_state", 32'(state), 32'd7);
      chk("trap_hold_flag", 32'(trap), 32'd1);
      chk("trap_hold_enables", 32'({mem_req, ir_we, reg_we, pc_we, retire}), 32'd0);
      @(posedge clk);
      #1;
    end
    do_reset();
    resp_mode = 1'b0;
  endtask

  task automatic do_instr(input logic [31:0] ins, input logic e, input int df, input int dm,
                          input int idle);
    exp_t x;
    bit done;
    run = 1'b0;
    for (int i = 0; i < idle; i++) begin
      @(posedge clk);
      #1;
    end
    instr = ins;
    eq = e;
    fdel = df;
    mdel = dm;
    run = 1'b1;
    x = model(ins, e, df, dm, cyc_n);
    expq.push_back(x);
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (retire || trap) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL no_completion: instr 0x%08h gave no retire or trap in 60 cycles", ins);
    end
    @(posedge clk);
    #1;
    if (x.is_trap) trap_recover();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom();
    k = $urandom_range(0, 12);
    case (k)
      0, 1:    r[6:0] = 7'h33;
      2, 3:    r[6:0] = 7'h13;
      4, 5:    r[6:0] = 7'h03;
      6, 7:    r[6:0] = 7'h23;
      8, 9:    r[6:0] = 7'h63;
      10, 11:  r[6:0] = 7'h6F;
      default: while (is_legal(r[6:0])) r = $urandom();
    endcase
    return r;
  endfunction

  function automatic int rand_delay();
    return ($urandom_range(0, 11) == 0) ? int'($urandom_range(TO, TO + 1))
                                        : int'($urandom_range(0, TO - 1));
  endfunction

  initial begin
    run = 1'b1;
    #3;
    chk("init_state", 32'(state), 32'd0);
    chk("init_mem_req_gated", 32'(mem_req), 32'd0);
    chk("init_trap", 32'(trap), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    run = 1'b0;
    @(posedge clk);
    #1;

    do_instr(32'h00500093, 1'b0, 1, 0, 0);   // addi x1,x0,5
    do_instr(32'h00000463, 1'b1, 0, 0, 1);   // beq taken
    do_instr(32'h00000463, 1'b0, 0, 0, 0);   // beq not taken
    do_instr(32'h00002103, 1'b0, 0, 3, 0);   // lw, ready on 4th mem cycle
    do_instr(32'h00202023, 1'b1, 2, 1, 2);   // sw
    do_instr(32'h0080006F, 1'b0, 0, 0, 0);   // jal
    do_instr(32'h002081B3, 1'b0, TO - 1, 0, 0); // ready in the last allowed fetch cycle
    do_instr(32'h00500093, 1'b0, TO, 0, 0);  // fetch timeout
    do_instr(32'h00000000, 1'b0, 0, 0, 0);   // illegal opcode
    do_instr(32'h00202023, 1'b0, 0, TO, 0);  // store timeout

    // Reset while a fetch is stalled: the request must drop immediately.
    instr = 32'h00500093;
    fdel = 50;
    run = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("midwait_req_before_rst", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("midwait_req_dropped", 32'(mem_req), 32'd0);
    chk("midwait_state", 32'(state), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    run = 1'b0;
    retired = 0;
    @(posedge clk);
    #1;

    for (int n = 0; n < 150; n++) begin
      do_instr(rand_instr(), 1'($urandom_range(0, 1)), rand_delay(), rand_delay(),
               int'($urandom_range(0, 2)));
    end

    run = 1'b0;
    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control sequencer for the team's multi-cycle RV32I datapath; replaces the single-cycle control path.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Issues one-cycle enables to PC, IR, register file and a shared instruction/data memory port using a req/ready handshake.
- Detects illegal opcodes and memory timeouts and parks in TRAP.

Parameters:
- TIMEOUT, 16, maximum cycles mem_req may stay high without mem_ready before trapping (2..255).
- TW, $clog2(TIMEOUT), width of the wait counter (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  allow a new fetch to start.
- instr  in  32  IR contents (valid from DECODE onward).
- eq  in  1  ALU zero flag (rs1==rs2).
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write request (store).
- addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_we  out  1  latch memory read data into IR.
- reg_we  out  1  register file write.
- pc_we  out  1  PC update.
- pc_src  out  1  0 = PC+4, 1 = PC+imm.
- imm_src  out  3  0 = I, 1 = S, 2 = B, 3 = J.
- alu_src  out  1  0 = rs2, 1 = imm.
- alu_op  out  2  0 = add, 1 = sub, 2 = funct-decoded.
- result_src  out  2  0 = ALU, 1 = mem data, 2 = PC+4.
- retire  out  1  one-cycle pulse when an instruction completes.
- trap  out  1  sticky trap flag.
- state  out  3  current state encoding.
- instret  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset: all outputs 0, state = FETCH, wait counter 0, trap 0.
- Outputs are combinational from state and instr; state, counter and trap are registered.
- Opcode classes:
  - R = 0110011, I = 0010011, LD = 0000011, ST = 0100011, BR = 0100011 is not used; BR = 1100011, JAL = 1101111.
  - Any other opcode is illegal.
- FETCH:
  - Idle while run = 0.
  - With run = 1: mem_req = 1, addr_sel = 0.
  - On mem_ready: ir_we = 1, next state DECODE.
- DECODE:
  - Illegal opcode: next state TRAP.
  - Otherwise: next state EXEC.
- EXEC:
  - R: alu_src 0, alu_op 2, next WB.
  - I: alu_src 1, imm_src 0, alu_op 2, next WB.
  - LD/ST: alu_src 1, alu_op 0, imm_src 0 (LD) or 1 (ST), next MEM.
  - BR: alu_src 0, alu_op 1; taken = eq XOR funct3[0] (beq/bne). pc_we = 1, pc_src = taken, imm_src 2, retire = 1, next FETCH.
  - JAL: next WB.
- MEM:
  - mem_req = 1, addr_sel = 1, mem_we = (ST).
  - On mem_ready, LD: next WB.
  - On mem_ready, ST: pc_we = 1, pc_src 0, retire = 1, next FETCH.
- WB:
  - reg_we = 1 and pc_we = 1, retire = 1, next FETCH.
  - result_src: 0 for R/I, 1 for LD, 2 for JAL.
  - pc_src: 1 with imm_src 3 for JAL, otherwise 0.
- pc_we is asserted exactly once per instruction, in its final state, coincident with retire.
- Timeout:
  - The wait counter clears on entering FETCH (with run = 1) or MEM, and increments each request cycle without mem_ready.
  - If mem_ready is low while the counter = TIMEOUT-1: next state TRAP, with no enables that cycle.
  - mem_ready in the TIMEOUT-th cycle is still accepted.
- mem_ready when mem_req = 0 is ignored.
- TRAP:
  - All enables 0, trap = 1.
  - Held until reset; run is ignored.
- Async reset at any point, including mid-handshake: immediate return to the reset state; any pending request is dropped.
- State encoding: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 7.

Optional Feature:
- Macro: MULTICYCLE_INSTRET_EN.
- Defined: 32-bit instret increments on each retire pulse, wraps 0xFFFFFFFF→0, resets to 0.
- Undefined: instret is tied to 0 and no counter flops are inferred.

Decomposition:
- Package ctrl_pkg:
  - state_t enum.
  - Opcode localparams.
  - imm_src, alu_op and result_src encodings, shared with sign-extend and ALU.
- One natural sub-module: mem_wait_timer (counter plus timeout compare, clear and enable inputs), instantiated once.

Test Plan:
- addi x1,x0,5 (0x00500093), mem_ready after 1 cycle:
  - States FETCH→DECODE→EXEC→WB→FETCH.
  - In WB: reg_we = 1, pc_we = 1, result_src 0, retire = 1.
  - instret = 1 if the macro is defined.
- beq x0,x0,8 (0x00000463) with eq = 1: EXEC gives pc_we = 1, pc_src = 1, imm_src 2, no reg_we. Repeat with eq = 0: pc_src = 0.
- lw x2,0(x0) (0x00002103) with a 3-cycle ready delay in MEM:
  - mem_req held with addr_sel 1 and mem_we 0 for 3 cycles.
  - Then WB with result_src 1.
- sw x2,0(x0) (0x00202023): MEM gives mem_we = 1; on ready, pc_we = 1 and retire; reg_we never asserted.
- Illegal instr 0x00000000: DECODE→TRAP, trap = 1. run and mem_ready toggled afterwards have no effect; rst low clears to FETCH.
- TIMEOUT = 4, mem_ready held low in FETCH: TRAP entered after 4 request cycles. Repeat with ready in the 4th cycle: DECODE reached. Also pulse rst low mid-wait: mem_req drops asynchronously.
